// File: rtl/axi4_lite_slave_write.sv
// AXI4-Lite write responder: captures AW and W, applies a byte-strobed write to a local register file, returns B.
// Latency: last AW/W handshake at edge N -> BVALID high after edge N+2; one write per 4 cycles at best.
// Backpressure: a captured channel holds its READY low until the B handshake; BVALID holds while BREADY=0.
module axi4_lite_slave_write #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic [ADDR_WIDTH-1:0]       AWADDR,
  input  logic                        AWVALID,
  output logic                        AWREADY,
  input  logic [DATA_WIDTH-1:0]       WDATA,
  input  logic [DATA_WIDTH/8-1:0]     WSTRB,
  input  logic                        WVALID,
  output logic                        WREADY,
  output logic [1:0]                  BRESP,
  output logic                        BVALID,
  input  logic                        BREADY,
  input  logic [$clog2(NUM_REGS)-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0]       rd_data
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RESP
  } state_t;

  state_t                  state;
  logic                    aw_full;
  logic                    w_full;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [STRB_W-1:0]       w_strb;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

  logic                    aw_fire;
  logic                    w_fire;
  logic [IDX_W-1:0]        wr_idx;
  logic                    addr_ok;

  assign aw_fire = AWVALID & AWREADY;
  assign w_fire  = WVALID & WREADY;
  // Low address bits are ignored: unaligned addresses land on the containing word.
  assign wr_idx  = aw_addr[2 +: IDX_W];
  // Compare the whole address so anything past the register file is rejected, not aliased.
  assign addr_ok = aw_addr < ADDR_LIMIT;
  assign rd_data = regs[rd_idx];

  // Channel capture, write FSM, register file and registered handshake outputs.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= IDLE;
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BRESP   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (aw_fire) begin
            aw_addr <= AWADDR;
            aw_full <= 1'b1;
          end
          if (w_fire) begin
            w_data <= WDATA;
            w_strb <= WSTRB;
            w_full <= 1'b1;
          end
          // Both latches hold a beat: leave to decode; READYs are already low here.
          if (aw_full && w_full) begin
            state   <= WRITE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
          end else begin
            AWREADY <= !(aw_full | aw_fire);
            WREADY  <= !(w_full | w_fire);
          end
        end
        WRITE: begin
          if (addr_ok) begin
            for (int n = 0; n < STRB_W; n++) begin
              if (w_strb[n]) begin
                regs[wr_idx][8*n +: 8] <= w_data[8*n +: 8];
              end
            end
          end
          BRESP  <= addr_ok ? RESP_OKAY : RESP_SLVERR;
          BVALID <= 1'b1;
          state  <= RESP;
        end
        RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
